// File: rtl/eddsa_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// EdDSA verify-core arbiter.
package eddsa_arb_pkg;

  typedef enum logic {
    ARB,
    BUSY
  } arb_state_t;

  localparam int   MAX_REQ    = 8;
  localparam int   PICK_W     = $clog2(MAX_REQ);
  localparam logic VERDICT_OK = 1'b1;

  // Lowest offset from ptr (mod MAX_REQ) with valid set wins. Requests above
  // N_REQ are tied low by the caller, so this matches a mod-N_REQ scan.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                input logic [PICK_W-1:0]  ptr);
    logic [PICK_W-1:0] idx;
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + PICK_W'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/eddsa_verify_arbiter_if.sv
// Bundle of requester streams, core stream, core verdict and routed verdicts.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface eddsa_verify_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
);
  localparam int KEEP_W = DATA_W / 8;

  logic [N_REQ-1:0]        s_tvalid;
  logic [N_REQ-1:0]        s_tready;
  logic [N_REQ*DATA_W-1:0] s_tdata;
  logic [N_REQ*KEEP_W-1:0] s_tkeep;
  logic [N_REQ*ID_W-1:0]   s_tid;
  logic [N_REQ-1:0]        s_tlast;

  logic                    core_tvalid;
  logic                    core_tready;
  logic [DATA_W-1:0]       core_tdata;
  logic [KEEP_W-1:0]       core_tkeep;
  logic [ID_W-1:0]         core_tid;
  logic                    core_tlast;

  logic                    vres_valid;
  logic                    vres_ready;
  logic                    vres_data;

  logic [N_REQ-1:0]        res_valid;
  logic [N_REQ-1:0]        res_ready;
  logic                    res_data;

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tid, s_tlast,
    output s_tready,
    output core_tvalid, core_tdata, core_tkeep, core_tid, core_tlast,
    input  core_tready,
    input  vres_valid, vres_data,
    output vres_ready,
    output res_valid, res_data,
    input  res_ready
  );

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tid, s_tlast,
    input  s_tready,
    input  core_tvalid, core_tdata, core_tkeep, core_tid, core_tlast,
    output core_tready,
    output vres_valid, vres_data,
    input  vres_ready,
    input  res_valid, res_data,
    output res_ready
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester indices, one entry per packet in flight in the core.
module arb_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge aclk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/eddsa_verify_arbiter.sv
// Packet-granular round-robin share of one verify core among N_REQ streams,
// with in-order verdict routing. Define ARB_STATS_EN for per-requester counters.
module eddsa_verify_arbiter
  import eddsa_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6,
  parameter int TAG_DEPTH = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  eddsa_verify_arbiter_if.slave  bus,
  output logic                   err_orphan
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]    stat_pkt,
  output logic [N_REQ*32-1:0]    stat_fail
`endif
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int KEEP_W = DATA_W / 8;

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   grant, grant_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic               first_beat;

  logic [MAX_REQ-1:0] valid_ext;
  logic [PICK_W-1:0]  pick;

  logic               beat_hs;
  logic               last_hs;
  logic               push;
  logic               pop;
  logic               orphan;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDX_W-1:0]   head;

  logic [N_REQ-1:0]   s_tready_c;
  logic               core_tvalid_c;
  logic [DATA_W-1:0]  core_tdata_c;
  logic [KEEP_W-1:0]  core_tkeep_c;
  logic [ID_W-1:0]    core_tid_c;
  logic               core_tlast_c;
  logic [N_REQ-1:0]   res_valid_c;
  logic               vres_ready_c;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = bus.s_tvalid;
    pick                   = rr_pick(valid_ext, PICK_W'(rr_ptr));
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    rr_ptr_n      = rr_ptr;
    s_tready_c    = '0;
    core_tvalid_c = 1'b0;
    core_tdata_c  = '0;
    core_tkeep_c  = '0;
    core_tid_c    = '0;
    core_tlast_c  = 1'b0;
    beat_hs       = 1'b0;
    last_hs       = 1'b0;
    push          = 1'b0;

    case (state)
      ARB: begin
        // One bubble per packet: the winner is only registered here.
        if (!fifo_full && (|bus.s_tvalid)) begin
          grant_n = IDX_W'(pick);
          state_n = BUSY;
        end
      end
      BUSY: begin
        core_tvalid_c     = bus.s_tvalid[grant];
        core_tdata_c      = bus.s_tdata[int'(grant)*DATA_W +: DATA_W];
        core_tkeep_c      = bus.s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
        core_tid_c        = bus.s_tid[int'(grant)*ID_W +: ID_W];
        core_tlast_c      = bus.s_tlast[grant];
        s_tready_c[grant] = bus.core_tready;
        beat_hs           = core_tvalid_c && bus.core_tready;
        push              = beat_hs && first_beat;
        if (beat_hs && core_tlast_c) begin
          last_hs  = 1'b1;
          state_n  = ARB;
          rr_ptr_n = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);
        end
      end
      default: state_n = ARB;
    endcase
  end

  // Verdicts follow packet order; with nothing in flight they are swallowed.
  always_comb begin
    res_valid_c  = '0;
    vres_ready_c = 1'b0;
    pop          = 1'b0;
    orphan       = 1'b0;
    if (!fifo_empty) begin
      res_valid_c[head] = bus.vres_valid;
      vres_ready_c      = bus.res_ready[head];
      pop               = bus.vres_valid && bus.res_ready[head];
    end else begin
      vres_ready_c = bus.vres_valid;
      orphan       = bus.vres_valid;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ARB;
      grant      <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b1;
      err_orphan <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
      if (state == ARB) first_beat <= 1'b1;
      else if (push)    first_beat <= 1'b0;
      if (orphan) err_orphan <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .W     (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .din    (grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  assign bus.s_tready    = s_tready_c;
  assign bus.core_tvalid = core_tvalid_c;
  assign bus.core_tdata  = core_tdata_c;
  assign bus.core_tkeep  = core_tkeep_c;
  assign bus.core_tid    = core_tid_c;
  assign bus.core_tlast  = core_tlast_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.res_data    = bus.vres_data;
  assign bus.vres_ready  = vres_ready_c;

`ifdef ARB_STATS_EN
  logic [31:0] pkt_cnt  [N_REQ];
  logic [31:0] fail_cnt [N_REQ];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < N_REQ; i++) begin
        pkt_cnt[i]  <= '0;
        fail_cnt[i] <= '0;
      end
    end else begin
      if (last_hs) pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
      if (pop && (bus.vres_data != VERDICT_OK)) fail_cnt[head] <= fail_cnt[head] + 32'd1;
    end
  end

  always_comb begin
    stat_pkt  = '0;
    stat_fail = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_pkt[i*32 +: 32]  = pkt_cnt[i];
      stat_fail[i*32 +: 32] = fail_cnt[i];
    end
  end
`endif

endmodule

// File: doc/eddsa_verify_arbiter.md
Name: eddsa_verify_arbiter

Overview:
- Shares one sha512_eddsa_verify core between N_REQ host-side AXI-stream requesters.
- Arbitration is packet-granular and round-robin; a packet is never interleaved with another.
- Records the requester index of each packet sent to the core in an in-order tag FIFO, then routes each 1-bit verdict from the core back to the requester that sent the packet.
- Sits between the per-requester duplicate FIFOs (checksum branch) and the verify core; the check_sha instances consume the routed verdicts.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 512, stream data width; tkeep width is DATA_W/8.
- ID_W, 6, tid width.
- TAG_DEPTH, 8, maximum packets in flight inside the core (power of two).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- s_tvalid  in  N_REQ  per-requester valid.
- s_tready  out  N_REQ  per-requester ready.
- s_tdata  in  N_REQ*DATA_W  per-requester data, requester i at slice i.
- s_tkeep  in  N_REQ*DATA_W/8  per-requester keep.
- s_tid  in  N_REQ*ID_W  per-requester id.
- s_tlast  in  N_REQ  per-requester last.
- core_tvalid  out  1  to core input.
- core_tready  in  1  from core input.
- core_tdata  out  DATA_W  to core.
- core_tkeep  out  DATA_W/8  to core.
- core_tid  out  ID_W  to core.
- core_tlast  out  1  to core.
- vres_valid  in  1  core verdict valid.
- vres_ready  out  1  core verdict ready.
- vres_data  in  1  core verdict, 1 = signature ok.
- res_valid  out  N_REQ  routed verdict valid, one-hot.
- res_ready  in  N_REQ  routed verdict ready.
- res_data  out  1  verdict value, shared across requesters.
- err_orphan  out  1  sticky; set when a verdict arrives with the tag FIFO empty.

Behaviour:
- Reset values:
  - state = ARB, grant = 0, rr_ptr = 0, tag FIFO empty, err_orphan = 0.
  - All s_tready, core_tvalid, vres_ready and res_valid are 0.
- State ARB:
  - Scan the requesters whose s_tvalid=1, starting at rr_ptr and wrapping modulo N_REQ; the first one found wins.
  - The scan runs only when the tag FIFO is not full.
  - On a winner: register grant, go to BUSY. No beat transfers in the ARB cycle (one bubble per packet).
  - If no requester is valid, or the tag FIFO is full, stay in ARB.
- State BUSY:
  - core_* = s_*[grant], combinational mux, zero latency.
  - s_tready[grant] = core_tready; all other s_tready = 0.
  - The first handshaken beat pushes grant into the tag FIFO (flag first_beat, cleared on push).
  - The handshake of the beat with tlast=1 moves to ARB and sets rr_ptr = (grant+1) mod N_REQ.
  - A single-beat packet pushes its tag and returns to ARB in the same cycle.
- Verdict routing:
  - When the tag FIFO is not empty: res_valid[head] = vres_valid; res_data = vres_data; vres_ready = res_ready[head].
  - A verdict handshake pops the FIFO.
  - A push and a pop in the same cycle are legal; occupancy is unchanged.
  - Full is checked only in ARB, so a packet in progress never blocks on a full FIFO.
- Orphan verdict: vres_valid=1 with the tag FIFO empty → vres_ready=1 (verdict discarded), err_orphan set to 1 until reset.
- Reset mid-packet: the packet is abandoned and no verdict is routed. The core must be reset by the same areset.

Optional Feature:
- Macro: ARB_STATS_EN.
- With the macro defined, add per-requester 32-bit counters:
  - pkt_cnt, incremented on the tlast handshake.
  - fail_cnt, incremented on a verdict handshake with res_data=0.
  - Counters wrap and reset to 0.
  - Exposed as outputs stat_pkt (N_REQ*32) and stat_fail (N_REQ*32).
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package eddsa_arb_pkg holds:
  - typedef arb_state_t {ARB, BUSY}.
  - Constants MAX_REQ=8, VERDICT_OK=1'b1.
  - Function rr_pick(valid, ptr) returning the winning index.
- Sub-module arb_tag_fifo:
  - Synchronous FIFO of width clog2(N_REQ) and depth TAG_DEPTH.
  - Outputs full, empty, head.

Test Plan:
- Single requester 0 sends a 3-beat packet, core verdict 1 → exactly 3 beats on core_*, one tag push, res_valid[0]=1 with res_data=1; res_valid[1] stays 0.
- Both requesters hold valid continuously, 2-beat packets each → core sees the order req0, req1, req0, req1; no interleaving; one bubble cycle between packets.
- req1 packet, then req0 packet, verdicts 0 then 1 → res_valid[1] with data 0 first, then res_valid[0] with data 1 (in-order tag routing).
- TAG_DEPTH=2, core withholds verdicts → third packet not granted (stays in ARB) until one verdict handshake.
- vres_valid=1 with no packet sent → vres_ready=1 and err_orphan=1, held after vres_valid drops.
- areset pulsed mid-packet → all outputs return to reset values next cycle; the next packet grants from requester 0.
